// File: rtl/bmp_header_parser.sv
// BMP header front-end: walks the first 34 header bytes, validates them and
// registers the frame geometry for the downstream crop engine.
module bmp_header_parser #(
    parameter int ADDR_W = 15,
    parameter int MAX_W  = 320,
    parameter int MAX_H  = 240
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        error_code,
    output logic [15:0]       img_width,
    output logic [15:0]       img_height,
    output logic              top_down,
    output logic [4:0]        bpp,
    output logic [31:0]       pixel_offset,
    output logic [15:0]       row_stride
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRead   = 2'd1;
    localparam logic [1:0] StCalc   = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(33);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Raw header fields, filled little-endian by shifting bytes in from the top.
    logic [15:0] sig_q, sig_d;
    logic [31:0] off_q, off_d;
    logic [31:0] wid_q, wid_d;
    logic [31:0] hgt_q, hgt_d;
    logic [15:0] bppr_q, bppr_d;
    logic [31:0] comp_q, comp_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [2:0]  code_q, code_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic        top_down_q, top_down_d;
    logic [4:0]  bpp_q, bpp_d;
    logic [31:0] offset_q, offset_d;
    logic [15:0] stride_q, stride_d;

    logic [31:0] abs_h;
    logic [18:0] prod;
    logic [13:0] words;
    logic [2:0]  calc_code;

    assign abs_h = hgt_q[31] ? (~hgt_q + 32'd1) : hgt_q;

    // Only the low 19 bits of width*bpp can reach the 16-bit stride, so the
    // modular product is exact for every width, not just legal ones.
    assign prod  = wid_q[18:0] * {3'b000, bppr_q};
    assign words = prod[18:5] + {13'd0, (prod[4:0] != 5'd0)};

    always_comb begin
        calc_code = 3'd0;
        if (sig_q != 16'h4D42) begin
            calc_code = 3'd1;
        end else if ((bppr_q != 16'd8) && (bppr_q != 16'd24)) begin
            calc_code = 3'd2;
        end else if (comp_q != 32'd0) begin
            calc_code = 3'd3;
        end else if ((wid_q == 32'd0) || (hgt_q == 32'd0)) begin
            calc_code = 3'd4;
        end else if ((wid_q > 32'(MAX_W)) || (abs_h > 32'(MAX_H))) begin
            calc_code = 3'd5;
        end else if (off_q < 32'd54) begin
            calc_code = 3'd6;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sig_d      = sig_q;
        off_d      = off_q;
        wid_d      = wid_q;
        hgt_d      = hgt_q;
        bppr_d     = bppr_q;
        comp_d     = comp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        code_d     = code_q;
        width_d    = width_q;
        height_d   = height_q;
        top_down_d = top_down_q;
        bpp_d      = bpp_q;
        offset_d   = offset_q;
        stride_d   = stride_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRead;
                    addr_d     = '0;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    code_d     = 3'd0;
                    width_d    = 16'd0;
                    height_d   = 16'd0;
                    top_down_d = 1'b0;
                    bpp_d      = 5'd0;
                    offset_d   = 32'd0;
                    stride_d   = 16'd0;
                end
            end
            StRead: begin
                if (addr_q <= ADDR_W'(1)) begin
                    sig_d = {mem_rdata, sig_q[15:8]};
                end
                if ((addr_q >= ADDR_W'(10)) && (addr_q <= ADDR_W'(13))) begin
                    off_d = {mem_rdata, off_q[31:8]};
                end
                if ((addr_q >= ADDR_W'(18)) && (addr_q <= ADDR_W'(21))) begin
                    wid_d = {mem_rdata, wid_q[31:8]};
                end
                if ((addr_q >= ADDR_W'(22)) && (addr_q <= ADDR_W'(25))) begin
                    hgt_d = {mem_rdata, hgt_q[31:8]};
                end
                if ((addr_q >= ADDR_W'(28)) && (addr_q <= ADDR_W'(29))) begin
                    bppr_d = {mem_rdata, bppr_q[15:8]};
                end
                if ((addr_q >= ADDR_W'(30)) && (addr_q <= LastAddr)) begin
                    comp_d = {mem_rdata, comp_q[31:8]};
                end
                if (addr_q == LastAddr) begin
                    state_d = StCalc;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            StCalc: begin
                state_d    = StFinish;
                done_d     = 1'b1;
                code_d     = calc_code;
                error_d    = (calc_code != 3'd0);
                width_d    = wid_q[15:0];
                height_d   = abs_h[15:0];
                top_down_d = hgt_q[31];
                bpp_d      = bppr_q[4:0];
                offset_d   = off_q;
                stride_d   = {words, 2'b00};
            end
            StFinish: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            sig_q      <= 16'd0;
            off_q      <= 32'd0;
            wid_q      <= 32'd0;
            hgt_q      <= 32'd0;
            bppr_q     <= 16'd0;
            comp_q     <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            code_q     <= 3'd0;
            width_q    <= 16'd0;
            height_q   <= 16'd0;
            top_down_q <= 1'b0;
            bpp_q      <= 5'd0;
            offset_q   <= 32'd0;
            stride_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sig_q      <= sig_d;
            off_q      <= off_d;
            wid_q      <= wid_d;
            hgt_q      <= hgt_d;
            bppr_q     <= bppr_d;
            comp_q     <= comp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            code_q     <= code_d;
            width_q    <= width_d;
            height_q   <= height_d;
            top_down_q <= top_down_d;
            bpp_q      <= bpp_d;
            offset_q   <= offset_d;
            stride_q   <= stride_d;
        end
    end

    assign mem_addr     = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign error_code   = code_q;
    assign img_width    = width_q;
    assign img_height   = height_q;
    assign top_down     = top_down_q;
    assign bpp          = bpp_q;
    assign pixel_offset = offset_q;
    assign row_stride   = stride_q;

endmodule

// File: tb/tb_bmp_header_parser.sv
// Randomised bench for bmp_header_parser with an arithmetic header model and
// a hold-stability compare process.
module tb_bmp_header_parser;

    localparam int ADDR_W = 15;
    localparam int MAX_W  = 320;
    localparam int MAX_H  = 240;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              busy, done, error, top_down;
    logic [2:0]        error_code;
    logic [15:0]       img_width, img_height, row_stride;
    logic [4:0]        bpp;
    logic [31:0]       pixel_offset;

    logic [7:0] img [34];

    typedef struct {
        logic        err;
        logic [2:0]  code;
        logic [15:0] w;
        logic [15:0] h;
        logic        td;
        logic [4:0]  bpp;
        logic [31:0] off;
        logic [15:0] stride;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    bit   hold_en = 1'b0;
    exp_t hold_e;

    bmp_header_parser #(.ADDR_W(ADDR_W), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_code  (error_code),
        .img_width   (img_width),
        .img_height  (img_height),
        .top_down    (top_down),
        .bpp         (bpp),
        .pixel_offset(pixel_offset),
        .row_stride  (row_stride)
    );

    always #10 clk = ~clk;

    assign mem_rdata = (mem_addr < ADDR_W'(34)) ? img[mem_addr[5:0]] : 8'h00;

    always @(posedge clk) #1 if (done) done_cnt++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t        e;
        logic [31:0] w32, h32, o32, c32;
        logic [15:0] b16;
        longint      wv, hs, ah, st;
        w32 = {img[21], img[20], img[19], img[18]};
        h32 = {img[25], img[24], img[23], img[22]};
        o32 = {img[13], img[12], img[11], img[10]};
        c32 = {img[33], img[32], img[31], img[30]};
        b16 = {img[29], img[28]};
        wv  = longint'(w32);
        hs  = longint'($signed(h32));
        ah  = (hs < 0) ? -hs : hs;
        st  = ((wv * longint'(b16) + 31) / 32) * 4;
        e.w      = w32[15:0];
        e.h      = ah[15:0];
        e.td     = (hs < 0);
        e.bpp    = b16[4:0];
        e.off    = o32;
        e.stride = st[15:0];
        if (img[0] != 8'h42 || img[1] != 8'h4D)  e.code = 3'd1;
        else if (b16 != 16'd8 && b16 != 16'd24) e.code = 3'd2;
        else if (c32 != 32'd0)                   e.code = 3'd3;
        else if (wv == 0 || hs == 0)             e.code = 3'd4;
        else if (wv > MAX_W || ah > MAX_H)       e.code = 3'd5;
        else if (o32 < 32'd54)                   e.code = 3'd6;
        else                                     e.code = 3'd0;
        e.err = (e.code != 3'd0);
        return e;
    endfunction

    task automatic build(input logic [7:0] s0, input logic [7:0] s1, input logic [31:0] off,
                         input logic [31:0] w, input logic [31:0] h, input logic [15:0] bp,
                         input logic [31:0] comp);
        for (int i = 0; i < 34; i++) img[i] = 8'($urandom);
        img[0] = s0;
        img[1] = s1;
        for (int i = 0; i < 4; i++) begin
            img[10+i] = off[8*i +: 8];
            img[18+i] = w[8*i +: 8];
            img[22+i] = h[8*i +: 8];
            img[30+i] = comp[8*i +: 8];
        end
        img[28] = bp[7:0];
        img[29] = bp[15:8];
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, "_error"}, error, e.err);
        chk({tag, "_code"}, error_code, e.code);
        chk({tag, "_width"}, img_width, e.w);
        chk({tag, "_height"}, img_height, e.h);
        chk({tag, "_topdown"}, top_down, e.td);
        chk({tag, "_bpp"}, bpp, e.bpp);
        chk({tag, "_offset"}, pixel_offset, e.off);
        chk({tag, "_stride"}, row_stride, e.stride);
    endtask

    // Run one parse of img[]; optionally re-pulse start at a given cycle.
    task automatic run(input string tag, input int repulse);
        exp_t e;
        int   lat;
        int   d0;
        e = model();
        @(negedge clk);
        hold_en = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        d0  = done_cnt;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == repulse);
            if (!done) chk({tag, "_busy"}, busy, 1);
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, 35);
        check_outs(tag, e);
        chk({tag, "_mem_addr"}, mem_addr, 33);
        hold_e  = e;
        hold_en = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    always @(negedge clk) begin
        if (hold_en) begin
            check_outs("hold", hold_e);
            chk("hold_mem_addr", mem_addr, 33);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_code"}, error_code, 0);
        chk({tag, "_width"}, img_width, 0);
        chk({tag, "_height"}, img_height, 0);
        chk({tag, "_topdown"}, top_down, 0);
        chk({tag, "_bpp"}, bpp, 0);
        chk({tag, "_offset"}, pixel_offset, 0);
        chk({tag, "_stride"}, row_stride, 0);
    endtask

    initial begin
        int          d0;
        logic [31:0] w, h, off, comp;
        logic [15:0] bp;
        logic [7:0]  s1;

        for (int i = 0; i < 34; i++) img[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        build(8'h42, 8'h4D, 32'd54, 32'd50, 32'd38, 16'd24, 32'd0);
        run("t24", 0);
        chk("t24_lit_width", img_width, 50);
        chk("t24_lit_height", img_height, 38);
        chk("t24_lit_stride", row_stride, 152);
        chk("t24_lit_bpp", bpp, 24);
        chk("t24_lit_topdown", top_down, 0);
        chk("t24_lit_error", error, 0);

        build(8'h42, 8'h4D, 32'd1078, 32'd61, -32'sd20, 16'd8, 32'd0);
        run("t8", 0);
        chk("t8_lit_stride", row_stride, 64);
        chk("t8_lit_height", img_height, 20);
        chk("t8_lit_topdown", top_down, 1);
        chk("t8_lit_offset", pixel_offset, 1078);
        chk("t8_lit_error", error, 0);

        build(8'h42, 8'h41, 32'd54, 32'd10, 32'd10, 16'd16, 32'd0);
        run("sig", 0);
        chk("sig_lit_code", error_code, 1);
        chk("sig_lit_error", error, 1);
        build(8'h42, 8'h4D, 32'd54, 32'd10, 32'd10, 16'd16, 32'd0);
        run("bpp16", 0);
        chk("bpp16_lit_code", error_code, 2);
        build(8'h42, 8'h4D, 32'd54, 32'd10, 32'd10, 16'd8, 32'd1);
        run("comp", 0);
        chk("comp_lit_code", error_code, 3);
        build(8'h42, 8'h4D, 32'd54, 32'd0, 32'd10, 16'd8, 32'd0);
        run("w0", 0);
        chk("w0_lit_code", error_code, 4);
        build(8'h42, 8'h4D, 32'd54, 32'd321, 32'd10, 16'd8, 32'd0);
        run("w321", 0);
        chk("w321_lit_code", error_code, 5);
        build(8'h42, 8'h4D, 32'd54, 32'd10, 32'h8000_0000, 16'd8, 32'd0);
        run("hmin", 0);
        chk("hmin_lit_code", error_code, 5);
        build(8'h42, 8'h4D, 32'd54, 32'd320, 32'd240, 16'd24, 32'd0);
        run("max", 0);
        chk("max_lit_error", error, 0);
        chk("max_lit_stride", row_stride, 960);
        build(8'h42, 8'h4D, 32'd53, 32'd10, 32'd10, 16'd8, 32'd0);
        run("off53", 0);
        chk("off53_lit_code", error_code, 6);

        // Reset in the middle of READ: abort with no done pulse.
        build(8'h42, 8'h4D, 32'd54, 32'd100, 32'd100, 16'd24, 32'd0);
        @(negedge clk);
        hold_en = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("abort_busy_before", busy, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1 check_zero("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("abort_no_done", done_cnt - d0, 0);
        run("restart", 0);

        build(8'h42, 8'h4D, 32'd200, 32'd77, -32'sd99, 16'd24, 32'd0);
        run("repulse", 5);

        for (int n = 0; n < 25; n++) begin
            s1   = ($urandom_range(0, 9) == 0) ? 8'h41 : 8'h4D;
            case ($urandom_range(0, 5))
                0:       bp = 16'd16;
                1:       bp = 16'd32;
                2, 3:    bp = 16'd8;
                default: bp = 16'd24;
            endcase
            comp = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
            w    = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 330));
            h    = 32'($signed($urandom_range(0, 500)) - 250);
            if ($urandom_range(0, 19) == 0) h = 32'h8000_0000;
            off  = 32'($urandom_range(40, 2000));
            build(8'h42, s1, off, w, h, bp, comp);
            run("rand", ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : 0);
        end

        hold_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
